issue_scheduler: RTL and testbench

//  Picks reservation-station (RS) entries for the three issue-stage functional units (FUs):
//  ALU0, ALU1 and MEM. Selection is oldest-first, by ROB age. Grants are registered.

---
 rtl/issue_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_issue_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// Oldest-first issue selection for ALU0, ALU1 and MEM with registered grants,
// a MEM occupancy FSM with timeout, and flush handling.
module issue_scheduler #(
    parameter int RS_DEPTH    = 8,
    parameter int ROB_W       = 5,
    parameter int IDX_W       = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [RS_DEPTH-1:0]       i_rs_valid,
    input  logic [RS_DEPTH-1:0]       i_rs_src_rdy,
    input  logic [RS_DEPTH-1:0]       i_rs_is_mem,
    input  logic [RS_DEPTH*ROB_W-1:0] i_rs_rob,
    input  logic [ROB_W-1:0]          i_rob_head,
    input  logic                      i_mem_done,
    input  logic                      i_flush,
    output logic [2:0]                o_issue_valid,
    output logic [3*IDX_W-1:0]        o_issue_idx,
    output logic [RS_DEPTH-1:0]       o_rs_clear,
    output logic                      o_mem_busy,
    output logic                      o_mem_timeout
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_BUSY  = 2'd1,
        M_DRAIN = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Age is the distance from the ROB head modulo 2**ROB_W; strict '<' keeps ties on the lower index.
    function automatic pick_t pick_oldest(input logic [RS_DEPTH-1:0]       cand,
                                          input logic [RS_DEPTH*ROB_W-1:0] rob,
                                          input logic [ROB_W-1:0]          head);
        pick_t            r;
        logic [ROB_W-1:0] best_age;
        logic [ROB_W-1:0] age;
        r        = '0;
        best_age = '0;
        for (int k = 0; k < RS_DEPTH; k++) begin
            age = rob[k*ROB_W +: ROB_W] - head;
            if (cand[k] && (!r.found || (age < best_age))) begin
                r.found  = 1'b1;
                r.idx    = IDX_W'(k);
                best_age = age;
            end
        end
        return r;
    endfunction

    mem_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc_s;
    logic                at_limit_s;
    logic                timeout_q, timeout_d;
    logic [2:0]          valid_q, valid_d;
    logic [3*IDX_W-1:0]  idx_q, idx_d;
    logic [RS_DEPTH-1:0] clear_q, clear_d;
    logic [RS_DEPTH-1:0] elig_s, alu_cand_s, alu0_mask_s;
    pick_t               alu0_s, alu1_s, mem_s;

    // Grant selection; entries granted last cycle are still in the RS and must be skipped.
    always_comb begin
        elig_s      = i_rs_valid & i_rs_src_rdy & ~clear_q;
        alu_cand_s  = elig_s & ~i_rs_is_mem;
        alu0_s      = pick_oldest(alu_cand_s, i_rs_rob, i_rob_head);
        alu0_mask_s = '0;
        if (alu0_s.found) begin
            alu0_mask_s[alu0_s.idx] = 1'b1;
        end else begin
            alu0_mask_s = '0;
        end
        alu1_s  = pick_oldest(alu_cand_s & ~alu0_mask_s, i_rs_rob, i_rob_head);
        mem_s   = pick_oldest(elig_s & i_rs_is_mem, i_rs_rob, i_rob_head);
        valid_d = 3'b000;
        idx_d   = '0;
        clear_d = '0;
        if (!i_flush) begin
            if (alu0_s.found) begin
                valid_d[0]            = 1'b1;
                idx_d[0 +: IDX_W]     = alu0_s.idx;
                clear_d[alu0_s.idx]   = 1'b1;
            end else begin
                valid_d[0] = 1'b0;
            end
            if (alu1_s.found) begin
                valid_d[1]              = 1'b1;
                idx_d[IDX_W +: IDX_W]   = alu1_s.idx;
                clear_d[alu1_s.idx]     = 1'b1;
            end else begin
                valid_d[1] = 1'b0;
            end
            if (mem_s.found && (state_q == M_IDLE)) begin
                valid_d[2]              = 1'b1;
                idx_d[2*IDX_W +: IDX_W] = mem_s.idx;
                clear_d[mem_s.idx]      = 1'b1;
            end else begin
                valid_d[2] = 1'b0;
            end
        end else begin
            valid_d = 3'b000;
        end
    end

    // MEM occupancy FSM; completion takes priority over timeout, both over flush.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        at_limit_s = (cnt_q == CNT_W'(MEM_TIMEOUT));
        cnt_inc_s  = at_limit_s ? cnt_q : (cnt_q + CNT_W'(1));
        case (state_q)
            M_IDLE: begin
                if (valid_d[2]) begin
                    state_d = M_BUSY;
                    cnt_d   = '0;
                end else begin
                    state_d = M_IDLE;
                end
            end
            M_BUSY: begin
                if (i_mem_done) begin
                    state_d = M_IDLE;
                end else if (at_limit_s) begin
                    state_d   = M_IDLE;
                    timeout_d = 1'b1;
                end else if (i_flush) begin
                    state_d = M_DRAIN;
                    cnt_d   = cnt_inc_s;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            M_DRAIN: begin
                if (i_mem_done) begin
                    state_d = M_IDLE;
                end else if (at_limit_s) begin
                    state_d   = M_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d = M_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= M_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            valid_q   <= 3'b000;
            idx_q     <= '0;
            clear_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            clear_q   <= clear_d;
        end
    end

    assign o_issue_valid = valid_q;
    assign o_issue_idx   = idx_q;
    assign o_rs_clear    = clear_q;
    assign o_mem_busy    = (state_q != M_IDLE);
    assign o_mem_timeout = timeout_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed-vector bench for issue_scheduler with hand-computed expectations.
module tb_issue_scheduler;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rs_valid;
    logic [7:0]  rs_src_rdy;
    logic [7:0]  rs_is_mem;
    logic [39:0] rs_rob;
    logic [4:0]  rob_head;
    logic        mem_done;
    logic        flush;
    logic [2:0]  issue_valid;
    logic [8:0]  issue_idx;
    logic [7:0]  rs_clear;
    logic        mem_busy;
    logic        mem_timeout;

    int total_cnt;
    int pass_cnt;

    issue_scheduler dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rs_valid    (rs_valid),
        .i_rs_src_rdy  (rs_src_rdy),
        .i_rs_is_mem   (rs_is_mem),
        .i_rs_rob      (rs_rob),
        .i_rob_head    (rob_head),
        .i_mem_done    (mem_done),
        .i_flush       (flush),
        .o_issue_valid (issue_valid),
        .o_issue_idx   (issue_idx),
        .o_rs_clear    (rs_clear),
        .o_mem_busy    (mem_busy),
        .o_mem_timeout (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_grant(input string tag, input logic [2:0] v, input logic [8:0] idx,
                             input logic [7:0] clr);
        check({tag, ".valid"}, 32'(issue_valid), 32'(v));
        check({tag, ".idx"},   32'(issue_idx),   32'(idx));
        check({tag, ".clear"}, 32'(rs_clear),    32'(clr));
    endtask

    task automatic chk_mem(input string tag, input logic busy, input logic tmo);
        check({tag, ".busy"},    32'(mem_busy),    32'(busy));
        check({tag, ".timeout"}, 32'(mem_timeout), 32'(tmo));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_entry(input int k, input logic [4:0] rob, input logic is_mem);
        rs_valid[k]          = 1'b1;
        rs_src_rdy[k]        = 1'b1;
        rs_is_mem[k]         = is_mem;
        rs_rob[k*5 +: 5]     = rob;
    endtask

    task automatic drop(input int k);
        rs_valid[k]   = 1'b0;
        rs_src_rdy[k] = 1'b0;
    endtask

    initial begin
        total_cnt  = 0;
        pass_cnt   = 0;
        rst_n      = 1'b0;
        rs_valid   = 8'h00;
        rs_src_rdy = 8'h00;
        rs_is_mem  = 8'h00;
        rs_rob     = 40'h0;
        rob_head   = 5'd0;
        mem_done   = 1'b0;
        flush      = 1'b0;
        #2;
        chk_grant("reset", 3'b000, 9'd0, 8'h00);
        chk_mem("reset", 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // T2: rob 3,1,2 with head 0 -> idx1 to ALU0, idx2 to ALU1, idx0 afterwards
        add_entry(0, 5'd3, 1'b0);
        add_entry(1, 5'd1, 1'b0);
        add_entry(2, 5'd2, 1'b0);
        tick();
        chk_grant("t2a", 3'b011, {3'd0, 3'd2, 3'd1}, 8'b0000_0110);
        drop(1);
        drop(2);
        tick();
        chk_grant("t2b", 3'b001, {3'd0, 3'd0, 3'd0}, 8'b0000_0001);
        drop(0);
        tick();
        chk_grant("t2c", 3'b000, 9'd0, 8'h00);

        // T3: head 30, rob 1 (age 3) vs rob 31 (age 1)
        rob_head = 5'd30;
        add_entry(0, 5'd1, 1'b0);
        add_entry(1, 5'd31, 1'b0);
        tick();
        chk_grant("t3", 3'b011, {3'd0, 3'd0, 3'd1}, 8'b0000_0011);
        drop(0);
        drop(1);
        rob_head = 5'd0;
        tick();

        // equal age resolves to the lower index
        add_entry(5, 5'd7, 1'b0);
        add_entry(3, 5'd7, 1'b0);
        tick();
        chk_grant("tie", 3'b011, {3'd0, 3'd5, 3'd3}, 8'b0010_1000);
        drop(3);
        drop(5);
        tick();

        // T4: two MEM entries plus one ALU entry
        add_entry(4, 5'd6, 1'b1);
        add_entry(6, 5'd5, 1'b1);
        add_entry(2, 5'd9, 1'b0);
        tick();
        chk_grant("t4a", 3'b101, {3'd6, 3'd0, 3'd2}, 8'b0100_0100);
        chk_mem("t4a", 1'b1, 1'b0);
        drop(6);
        drop(2);
        tick();
        chk_grant("t4b", 3'b000, 9'd0, 8'h00);
        tick();
        chk_grant("t4c", 3'b000, 9'd0, 8'h00);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk_grant("t4d", 3'b000, 9'd0, 8'h00);
        chk_mem("t4d", 1'b0, 1'b0);
        tick();
        chk_grant("t4e", 3'b100, {3'd4, 3'd0, 3'd0}, 8'b0001_0000);
        chk_mem("t4e", 1'b1, 1'b0);
        drop(4);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk_mem("t4f", 1'b0, 1'b0);

        // flush in the same cycle as a MEM grant decision
        add_entry(7, 5'd2, 1'b1);
        add_entry(0, 5'd1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_grant("fl_grant", 3'b000, 9'd0, 8'h00);
        chk_mem("fl_grant", 1'b0, 1'b0);
        tick();
        chk_grant("fl_after", 3'b101, {3'd7, 3'd0, 3'd0}, 8'b1000_0001);
        chk_mem("fl_after", 1'b1, 1'b0);
        drop(7);
        drop(0);

        // T6: flush while BUSY -> DRAIN, then done -> IDLE
        add_entry(3, 5'd4, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_grant("t6a", 3'b000, 9'd0, 8'h00);
        chk_mem("t6a", 1'b1, 1'b0);
        tick();
        chk_grant("t6b", 3'b001, {3'd0, 3'd0, 3'd3}, 8'b0000_1000);
        chk_mem("t6b", 1'b1, 1'b0);
        drop(3);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk_mem("t6c", 1'b0, 1'b0);

        // done coinciding with the timeout cycle: done wins
        add_entry(5, 5'd0, 1'b1);
        tick();
        chk_grant("dt_grant", 3'b100, {3'd5, 3'd0, 3'd0}, 8'b0010_0000);
        drop(5);
        for (int i = 0; i < 15; i++) tick();
        chk_mem("dt_pre", 1'b1, 1'b0);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk_mem("dt_post", 1'b0, 1'b0);

        // T5: no completion -> sticky timeout
        add_entry(1, 5'd3, 1'b1);
        tick();
        chk_grant("t5_grant", 3'b100, {3'd1, 3'd0, 3'd0}, 8'b0000_0010);
        drop(1);
        for (int i = 0; i < 15; i++) tick();
        chk_mem("t5_pre", 1'b1, 1'b0);
        tick();
        chk_mem("t5_abort", 1'b0, 1'b1);
        tick();
        tick();
        chk_mem("t5_sticky", 1'b0, 1'b1);

        // T1: asynchronous reset in the middle of a grant cycle
        add_entry(0, 5'd1, 1'b0);
        add_entry(6, 5'd2, 1'b1);
        tick();
        chk_grant("t1_pre", 3'b101, {3'd6, 3'd0, 3'd0}, 8'b0100_0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk_grant("t1_rst", 3'b000, 9'd0, 8'h00);
        chk_mem("t1_rst", 1'b0, 1'b0);
        drop(0);
        drop(6);
        tick();
        rst_n = 1'b1;
        tick();
        chk_grant("t1_idle", 3'b000, 9'd0, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
